// File: rtl/store_check_monitor_if.sv
// Data-memory write-port bundle observed by store_check_monitor.
// The core drives it through master; the monitor only watches through slave.
interface store_check_monitor_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              MemWrite;
  logic [ADDR_W-1:0] DataAdr;
  logic [DATA_W-1:0] WriteData;

  modport master (output MemWrite, DataAdr, WriteData);
  modport slave  (input  MemWrite, DataAdr, WriteData);
endinterface

// File: rtl/store_check_monitor.sv
// In-order checker of data-memory stores against a programmable table, with watchdog.
// Define STORE_CHECK_IGNORE_EN to silently skip non-matching stores inside [IGN_LO, IGN_HI].
//
// state  | meaning
// S_IDLE | table programmable, waiting for start
// S_RUN  | checking stores in order, watchdog running
// S_PASS | all active entries matched (sticky)
// S_FAIL | a store mismatched; offending store captured (sticky)
// S_TOUT | watchdog expired before completion (sticky)
module store_check_monitor #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 1000,
  parameter int IGN_LO  = 96,
  parameter int IGN_HI  = 96,
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 reset,
  store_check_monitor_if.slave bus,
  input  logic                 cfg_we,
  input  logic [IDX_W-1:0]     cfg_idx,
  input  logic [ADDR_W-1:0]    cfg_adr,
  input  logic [DATA_W-1:0]    cfg_data,
  input  logic [CNT_W-1:0]     cfg_num,
  input  logic                 start,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [CNT_W-1:0]     match_cnt,
  output logic [ADDR_W-1:0]    fail_adr,
  output logic [DATA_W-1:0]    fail_data
);

  typedef enum logic [2:0] {S_IDLE, S_RUN, S_PASS, S_FAIL, S_TOUT} state_t;

  // Down-counter holds remaining RUN cycles minus one; expiry is its zero compare.
  localparam int WD_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0] WD_LOAD = WD_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_t            state;
  logic [ADDR_W-1:0] exp_adr  [DEPTH];
  logic [DATA_W-1:0] exp_data [DEPTH];
  logic [CNT_W-1:0]  num;
  logic [WD_W-1:0]   wd_cnt;

  logic [ADDR_W-1:0] cur_adr;
  logic [DATA_W-1:0] cur_data;
  logic [CNT_W-1:0]  num_sat;
  logic [CNT_W-1:0]  match_inc;
  logic              hit;
  logic              skip;
  logic              wd_expire;

  always_comb begin
    cur_adr  = '0;
    cur_data = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (match_cnt == CNT_W'(i)) begin
        cur_adr  = exp_adr[i];
        cur_data = exp_data[i];
      end
    end
  end

  assign num_sat   = (cfg_num > CNT_W'(DEPTH)) ? CNT_W'(DEPTH) : cfg_num;
  assign match_inc = match_cnt + CNT_W'(1);
  assign hit       = (bus.DataAdr == cur_adr) && (bus.WriteData == cur_data);
  assign wd_expire = (TIMEOUT != 0) && (wd_cnt == '0);

`ifdef STORE_CHECK_IGNORE_EN
  assign skip = (bus.DataAdr >= ADDR_W'(IGN_LO)) && (bus.DataAdr <= ADDR_W'(IGN_HI));
`else
  assign skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= S_IDLE;
      num       <= '0;
      wd_cnt    <= '0;
      match_cnt <= '0;
      done      <= 1'b0;
      pass      <= 1'b0;
      fail      <= 1'b0;
      timeout   <= 1'b0;
      fail_adr  <= '0;
      fail_data <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        exp_adr[i]  <= '0;
        exp_data[i] <= '0;
      end
    end else begin
      case (state)
        S_RUN: begin
          if (wd_cnt != '0) wd_cnt <= wd_cnt - WD_W'(1);
          // Priority: final match, then mismatch, then watchdog.
          if (bus.MemWrite && hit) begin
            match_cnt <= match_inc;
            if (match_inc == num) begin
              state <= S_PASS;
              pass  <= 1'b1;
              done  <= 1'b1;
            end else if (wd_expire) begin
              state   <= S_TOUT;
              timeout <= 1'b1;
              done    <= 1'b1;
            end
          end else if (bus.MemWrite && !skip) begin
            state     <= S_FAIL;
            fail      <= 1'b1;
            done      <= 1'b1;
            fail_adr  <= bus.DataAdr;
            fail_data <= bus.WriteData;
          end else if (wd_expire) begin
            state   <= S_TOUT;
            timeout <= 1'b1;
            done    <= 1'b1;
          end
        end
        default: begin
          if (cfg_we) begin
            for (int i = 0; i < DEPTH; i++) begin
              if (cfg_idx == IDX_W'(i)) begin
                exp_adr[i]  <= cfg_adr;
                exp_data[i] <= cfg_data;
              end
            end
          end
          if (start) begin
            num       <= num_sat;
            wd_cnt    <= WD_LOAD;
            match_cnt <= '0;
            fail      <= 1'b0;
            timeout   <= 1'b0;
            fail_adr  <= '0;
            fail_data <= '0;
            if (num_sat == '0) begin
              state <= S_PASS;
              pass  <= 1'b1;
              done  <= 1'b1;
            end else begin
              state <= S_RUN;
              pass  <= 1'b0;
              done  <= 1'b0;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_store_check_monitor.sv
// Directed bench for store_check_monitor: behavioural model checked every cycle,
// plus literal expectations at the decisive points of each scenario.
module tb_store_check_monitor;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int TMO = 10;
  localparam int IGN_LO = 96;
  localparam int IGN_HI = 96;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_idx = '0;
  logic [AW-1:0] cfg_adr = '0;
  logic [DW-1:0] cfg_data = '0;
  logic [2:0] cfg_num = '0;
  logic start = 1'b0;
  logic done, pass, fail, timeout;
  logic [2:0] match_cnt;
  logic [AW-1:0] fail_adr;
  logic [DW-1:0] fail_data;

  int total = 0;
  int bad = 0;

  store_check_monitor_if #(.ADDR_W(AW), .DATA_W(DW)) bus ();

  store_check_monitor #(
    .ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .TIMEOUT(TMO),
    .IGN_LO(IGN_LO), .IGN_HI(IGN_HI)
  ) dut (
    .clk(clk), .reset(rst), .bus(bus),
    .cfg_we(cfg_we), .cfg_idx(cfg_idx), .cfg_adr(cfg_adr), .cfg_data(cfg_data),
    .cfg_num(cfg_num), .start(start),
    .done(done), .pass(pass), .fail(fail), .timeout(timeout),
    .match_cnt(match_cnt), .fail_adr(fail_adr), .fail_data(fail_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // result: 0 none, 1 pass, 2 fail, 3 timeout
  longint m_adr [DEPTH];
  longint m_data [DEPTH];
  int m_num = 0, m_cnt = 0, m_cycles = 0, m_result = 0;
  bit m_running = 0;
  longint m_fa = 0, m_fd = 0;

  function automatic bit ignorable(input longint a);
`ifdef STORE_CHECK_IGNORE_EN
    return (a >= IGN_LO) && (a <= IGN_HI);
`else
    return (a < 0);
`endif
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin m_adr[i] = 0; m_data[i] = 0; end
      m_num = 0; m_cnt = 0; m_cycles = 0; m_result = 0; m_running = 0;
      m_fa = 0; m_fd = 0;
    end else if (!m_running) begin
      if (cfg_we && int'(cfg_idx) < DEPTH) begin
        m_adr[cfg_idx] = cfg_adr;
        m_data[cfg_idx] = cfg_data;
      end
      if (start) begin
        m_num = (int'(cfg_num) > DEPTH) ? DEPTH : int'(cfg_num);
        m_cnt = 0; m_cycles = 0; m_fa = 0; m_fd = 0;
        m_result = (m_num == 0) ? 1 : 0;
        m_running = (m_num != 0);
      end
    end else begin
      m_cycles++;
      if (bus.MemWrite) begin
        if (longint'(bus.DataAdr) == m_adr[m_cnt] && longint'(bus.WriteData) == m_data[m_cnt]) begin
          m_cnt++;
          if (m_cnt == m_num) begin m_result = 1; m_running = 0; end
        end else if (!ignorable(longint'(bus.DataAdr))) begin
          m_result = 2; m_running = 0;
          m_fa = bus.DataAdr; m_fd = bus.WriteData;
        end
      end
      if (m_running && TMO != 0 && m_cycles == TMO) begin
        m_result = 3; m_running = 0;
      end
    end
  end

  always @(negedge clk) begin
    chk("pass", pass, 64'(m_result == 1));
    chk("fail", fail, 64'(m_result == 2));
    chk("timeout", timeout, 64'(m_result == 3));
    chk("done", done, 64'(m_result != 0));
    chk("match_cnt", match_cnt, 64'(m_cnt));
    chk("fail_adr", fail_adr, 64'(m_fa));
    chk("fail_data", fail_data, 64'(m_fd));
  end

  // ---------------- stimulus ----------------
  task automatic write_entry(input int idx, input int adr, input int data);
    cfg_we = 1'b1; cfg_idx = 2'(idx); cfg_adr = AW'(adr); cfg_data = DW'(data);
    @(negedge clk);
    cfg_we = 1'b0;
  endtask

  task automatic do_start(input int n);
    start = 1'b1; cfg_num = 3'(n);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic store(input int adr, input int data);
    bus.MemWrite = 1'b1; bus.DataAdr = AW'(adr); bus.WriteData = DW'(data);
    @(negedge clk);
    bus.MemWrite = 1'b0;
  endtask

  task automatic idle_cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_zero"}, {done, pass, fail, timeout, match_cnt, fail_adr[15:0], fail_data[15:0]}, 64'd0);
  endtask

  initial begin
    bus.MemWrite = 1'b0; bus.DataAdr = '0; bus.WriteData = '0;
    idle_cyc(2);
    chk_all_zero("reset");
    rst = 1'b1;
    idle_cyc(1);

    // single check
    write_entry(0, 100, 25);
    do_start(1);
    chk("single_run_pass", pass, 64'd0);
    store(100, 25);
    chk("single_pass", pass, 64'd1);
    chk("single_done", done, 64'd1);
    chk("single_cnt", match_cnt, 64'd1);

    // ordered multi-check
    write_entry(0, 96, 7);
    write_entry(1, 100, 25);
    write_entry(2, 104, 3);
    do_start(3);
    store(96, 7);
    store(100, 25);
    chk("multi_mid_cnt", match_cnt, 64'd2);
    chk("multi_mid_done", done, 64'd0);
    store(104, 3);
    chk("multi_pass", pass, 64'd1);
    chk("multi_cnt", match_cnt, 64'd3);

    // out of order, restarted from PASS
    do_start(3);
    store(100, 25);
    chk("order_fail", fail, 64'd1);
    chk("order_fail_adr", fail_adr, 64'd100);
    chk("order_cnt", match_cnt, 64'd0);

    // mismatch capture
    write_entry(0, 100, 25);
    do_start(1);
    store(100, 24);
    chk("mis_fail", fail, 64'd1);
    chk("mis_adr", fail_adr, 64'd100);
    chk("mis_data", fail_data, 64'd24);
    chk("mis_cnt", match_cnt, 64'd0);

    // ignore window
    do_start(1);
    store(96, 99);
    store(100, 25);
`ifdef STORE_CHECK_IGNORE_EN
    chk("ign_pass", pass, 64'd1);
    chk("ign_cnt", match_cnt, 64'd1);
`else
    chk("ign_fail", fail, 64'd1);
    chk("ign_adr", fail_adr, 64'd96);
    chk("ign_data", fail_data, 64'd99);
`endif

    // table frozen during RUN
    do_start(1);
    write_entry(0, 200, 1);
    store(100, 25);
    chk("frozen_pass", pass, 64'd1);

    // watchdog
    do_start(1);
    idle_cyc(TMO - 1);
    chk("wd_early", timeout, 64'd0);
    idle_cyc(1);
    chk("wd_tout", timeout, 64'd1);
    chk("wd_done", done, 64'd1);

    // final match on the watchdog cycle wins
    do_start(1);
    idle_cyc(TMO - 1);
    store(100, 25);
    chk("wd_match_pass", pass, 64'd1);
    chk("wd_match_tout", timeout, 64'd0);

    // mismatch on the watchdog cycle wins
    do_start(1);
    idle_cyc(TMO - 1);
    store(100, 1);
    chk("wd_mis_fail", fail, 64'd1);
    chk("wd_mis_data", fail_data, 64'd1);

    // num zero passes immediately
    do_start(0);
    chk("zero_pass", pass, 64'd1);
    chk("zero_cnt", match_cnt, 64'd0);

    // cfg_num saturates at DEPTH
    write_entry(0, 96, 7);
    write_entry(3, 108, 9);
    do_start(7);
    store(96, 7);
    store(100, 25);
    store(104, 3);
    chk("sat_mid", done, 64'd0);
    store(108, 9);
    chk("sat_pass", pass, 64'd1);
    chk("sat_cnt", match_cnt, 64'd4);

    // reset mid-run
    do_start(3);
    store(96, 7);
    chk("rst_pre_cnt", match_cnt, 64'd1);
    #2 rst = 1'b0;
    #1 chk_all_zero("rst_async");
    @(negedge clk);
    rst = 1'b1;
    store(96, 7);
    chk_all_zero("rst_idle");
    do_start(1);
    store(0, 0);
    chk("rst_table_cleared", pass, 64'd1);

    idle_cyc(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
